seq_multiplier_nbits: RTL and testbench



---
 rtl/seq_multiplier_nbits_pkg.sv | 15 +
 rtl/seq_mult_ctrl.sv | 72 +++++++
 rtl/seq_multiplier_nbits.sv | 74 +++++++
 tb/tb_seq_multiplier_nbits.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/seq_multiplier_nbits_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// FSM state encoding and the iteration-counter width helper.
package seq_multiplier_nbits_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/seq_mult_ctrl.sv
// Control path for seq_multiplier_nbits: IDLE/RUN/DONE sequencing,
// iteration counter and busy/done generation.
module seq_mult_ctrl
  import seq_multiplier_nbits_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_start,
  output logic o_busy,
  output logic o_done,
  output logic o_load,
  output logic o_step,
  output logic o_last
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CW-1:0]   r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (o_load)
        r_cnt <= '0;
      else if (o_step)
        r_cnt <= r_cnt + 1'b1;
    end
  end

  // DONE is not busy, so a start seen there launches the next operation directly.
  always_comb begin
    w_state_nxt = r_state;
    o_load      = 1'b0;
    o_step      = 1'b0;
    o_last      = 1'b0;
    o_busy      = (r_state == ST_RUN);
    o_done      = (r_state == ST_DONE);
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          o_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        o_step = 1'b1;
        if (r_cnt == LAST_CNT) begin
          o_last      = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        if (i_start) begin
          o_load      = 1'b1;
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/seq_multiplier_nbits.sv
// Parametrised sequential shift-and-add multiplier with optional signed mode;
// one partial product per clock, exact 2*WIDTH-bit result.
module seq_multiplier_nbits
  import seq_multiplier_nbits_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   p
);

  logic                 w_load;
  logic                 w_step;
  logic                 w_last;
  logic                 w_mode_s;
  logic [WIDTH-1:0]     w_a_mag;
  logic [WIDTH-1:0]     w_b_mag;
  logic [2*WIDTH-1:0]   w_acc_sum;

  logic [2*WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]     r_mplier;
  logic [2*WIDTH-1:0]   r_acc;
  logic                 r_neg;
  logic [2*WIDTH-1:0]   r_p;

  seq_mult_ctrl #(.WIDTH(WIDTH)) u_ctrl (
    .i_clk   (clk),
    .i_reset (reset),
    .i_start (start),
    .o_busy  (busy),
    .o_done  (done),
    .o_load  (w_load),
    .o_step  (w_step),
    .o_last  (w_last)
  );

  // The most negative operand negates to 2^(WIDTH-1), which still fits unsigned.
  assign w_mode_s  = SIGNED_EN && signed_mode;
  assign w_a_mag   = (w_mode_s && a[WIDTH-1]) ? -a : a;
  assign w_b_mag   = (w_mode_s && b[WIDTH-1]) ? -b : b;
  assign w_acc_sum = r_acc + (r_mplier[0] ? r_mcand : '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_neg    <= 1'b0;
      r_p      <= '0;
    end else if (w_load) begin
      r_mcand  <= {{WIDTH{1'b0}}, w_a_mag};
      r_mplier <= w_b_mag;
      r_acc    <= '0;
      r_neg    <= w_mode_s && (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (w_step) begin
      r_acc    <= w_acc_sum;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      if (w_last)
        r_p <= r_neg ? -w_acc_sum : w_acc_sum;
    end
  end

  assign p = r_p;

endmodule

// File: tb/tb_seq_multiplier_nbits.sv
// Self-checking bench for seq_multiplier_nbits: cycle-level reference model
// with per-cycle comparison, directed literal cases and randomized traffic.
module tb_seq_multiplier_nbits;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           reset, start, sm;
  logic [W-1:0]   a, b;
  logic           busy, done;
  logic [2*W-1:0] p;

  logic           u_start, u_sm;
  logic [W-1:0]   u_a, u_b;
  logic           u_busy, u_done;
  logic [2*W-1:0] u_p;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  seq_multiplier_nbits #(.WIDTH(W), .SIGNED_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(sm),
    .a(a), .b(b), .busy(busy), .done(done), .p(p)
  );

  seq_multiplier_nbits #(.WIDTH(W), .SIGNED_EN(1'b0)) dut_u (
    .clk(clk), .reset(reset), .start(u_start), .signed_mode(u_sm),
    .a(u_a), .b(u_b), .busy(u_busy), .done(u_done), .p(u_p)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y,
                                             input logic sgn);
    int xi, yi, r;
    xi = sgn ? int'($signed(x)) : int'(x);
    yi = sgn ? int'($signed(y)) : int'(y);
    r  = xi * yi;
    return r[2*W-1:0];
  endfunction

  // Reference: an accepted op completes W edges later with the exact product.
  logic           m_busy = 1'b0, m_done = 1'b0;
  logic [2*W-1:0] m_p = '0, m_pend = '0;
  int             m_rem = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_busy = 1'b0; m_done = 1'b0; m_p = '0; m_rem = 0;
    end else if (m_busy) begin
      m_rem--;
      if (m_rem == 0) begin
        m_busy = 1'b0; m_done = 1'b1; m_p = m_pend;
      end
    end else begin
      m_done = 1'b0;
      if (start) begin
        m_busy = 1'b1; m_rem = W; m_pend = ref_mul(a, b, sm);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", {31'b0, busy}, {31'b0, m_busy});
      chk("done", {31'b0, done}, {31'b0, m_done});
      chk("p", {16'b0, p}, {16'b0, m_p});
    end
  end

  task automatic wait_done(input bit drop, output int bc, output bit ok);
    bc = 0; ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (drop && i == 0) start = 1'b0;
      if (busy) bc++;
      if (done) begin ok = 1'b1; break; end
    end
  endtask

  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic sgn, input logic [2*W-1:0] exp);
    int bc; bit ok;
    a = x; b = y; sm = sgn; start = 1'b1;
    wait_done(1'b1, bc, ok);
    chk({name, "_done_seen"}, {31'b0, ok}, 32'd1);
    chk({name, "_busy_len"}, bc, W);
    chk(name, {16'b0, p}, {16'b0, exp});
  endtask

  task automatic u_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                      input logic sgn, input logic [2*W-1:0] exp);
    bit ok;
    ok = 1'b0;
    u_a = x; u_b = y; u_sm = sgn; u_start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      u_start = 1'b0;
      if (u_done) begin ok = 1'b1; break; end
    end
    chk({name, "_done_seen"}, {31'b0, ok}, 32'd1);
    chk(name, {16'b0, u_p}, {16'b0, exp});
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "timeout");
  end

  initial begin
    int bc, dcnt; bit ok;
    logic [W-1:0] ra, rb; logic rs;
    reset = 1'b1; start = 1'b0; sm = 1'b0; a = '0; b = '0;
    u_start = 1'b0; u_sm = 1'b0; u_a = '0; u_b = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_p", {16'b0, p}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    run_op("u_15x13", 8'd15, 8'd13, 1'b0, 16'h00C3);
    run_op("u_255x255", 8'd255, 8'd255, 1'b0, 16'hFE01);
    run_op("u_0x200", 8'd0, 8'd200, 1'b0, 16'h0000);
    run_op("s_m3x5", 8'hFD, 8'd5, 1'b1, 16'hFFF1);
    run_op("s_m128xm128", 8'h80, 8'h80, 1'b1, 16'h4000);
    run_op("s_m128x1", 8'h80, 8'd1, 1'b1, 16'hFF80);
    repeat (2) @(negedge clk);

    // Start held high; operand change mid-run only affects the back-to-back op.
    a = 8'd7; b = 8'd6; sm = 1'b0; start = 1'b1;
    repeat (3) @(negedge clk);
    a = 8'd9;
    wait_done(1'b0, bc, ok);
    chk("b2b_first_seen", {31'b0, ok}, 32'd1);
    chk("b2b_first", {16'b0, p}, 32'd42);
    wait_done(1'b0, bc, ok);
    start = 1'b0;
    chk("b2b_second_seen", {31'b0, ok}, 32'd1);
    chk("b2b_second_busy_len", bc, W);
    chk("b2b_second", {16'b0, p}, 32'd54);
    repeat (2) @(negedge clk);

    // Abort by reset in the fourth RUN cycle.
    a = 8'd50; b = 8'd3; start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_done", {31'b0, done}, 32'd0);
    chk("abort_p", {16'b0, p}, 32'd0);
    dcnt = 0;
    repeat (12) begin @(negedge clk); if (done) dcnt++; end
    chk("abort_no_done", dcnt, 0);
    run_op("after_abort_10x10", 8'd10, 8'd10, 1'b0, 16'd100);

    // Randomized traffic: starts while busy, operand churn, sporadic resets.
    for (int i = 0; i < 2500; i++) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      a = W'($urandom); b = W'($urandom); sm = 1'($urandom);
      reset = ($urandom_range(0, 149) == 0);
    end
    @(negedge clk);
    reset = 1'b0; start = 1'b0;
    repeat (12) @(negedge clk);

    u_op("nosign_fd_x5", 8'hFD, 8'd5, 1'b1, 16'h04F1);
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      u_op("nosign_rand", ra, rb, rs, ref_mul(ra, rb, 1'b0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
